module_call_dispatcher: RTL and testbench

//  Upstream driver for the all-function-types target module. Accepts call requests
//  (opcode + int argument) on a valid/ready channel and drives the target's *_x

---
 rtl/call_dispatch_pkg.sv | 26 ++
 rtl/module_call_dispatcher.sv | 146 ++++++++++++++
 tb/tb_module_call_dispatcher.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/call_dispatch_pkg.sv
// Shared types for the call dispatcher: opcodes, FSM states and stage latencies.
// Imported by module_call_dispatcher.
package call_dispatch_pkg;

    typedef enum logic [2:0] {
        OP_FUNC_NOP     = 3'd0,
        OP_FUNC_P       = 3'd1,
        OP_TOCK_NOP     = 3'd2,
        OP_TOCK_P_NORET = 3'd3,
        OP_TOCK_P_RET   = 3'd4,
        OP_TOCK_FUNCS   = 3'd5,
        OP_TICK_P       = 3'd6,
        OP_ILLEGAL      = 3'd7
    } call_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int ISSUE_LAT  = 1;
    localparam int SETTLE_LAT = 1;

endpackage

// File: rtl/module_call_dispatcher.sv
// Serialising call driver for the all-function-types target: one call
// in flight, parameters driven on *_x, settled result returned on rsp_*.
module module_call_dispatcher
    import call_dispatch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_arg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_op,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] issued_count,
    output logic [31:0]      func_params_return_x,
    output logic [31:0]      tock_params_no_return_x,
    output logic [31:0]      tock_params_return_x,
    output logic [31:0]      tock_calls_funcs_x,
    output logic [31:0]      tick_params_x,
    input  logic [31:0]      func_no_params_return_ret,
    input  logic [31:0]      func_params_return_ret,
    input  logic [31:0]      tock_no_params_return_ret,
    input  logic [31:0]      my_sig3,
    input  logic [31:0]      tock_params_return_ret,
    input  logic [31:0]      my_sig5,
    input  logic [31:0]      my_reg2
);

    function automatic logic [31:0] sel_result(
        input call_op_e    op,
        input logic [31:0] r0,
        input logic [31:0] r1,
        input logic [31:0] r2,
        input logic [31:0] r3,
        input logic [31:0] r4,
        input logic [31:0] r5,
        input logic [31:0] r6
    );
        logic [31:0] r;
        r = 32'd0;
        unique case (op)
            OP_FUNC_NOP:     r = r0;
            OP_FUNC_P:       r = r1;
            OP_TOCK_NOP:     r = r2;
            OP_TOCK_P_NORET: r = r3;
            OP_TOCK_P_RET:   r = r4;
            OP_TOCK_FUNCS:   r = r5;
            OP_TICK_P:       r = r6;
            default:         r = 32'd0;
        endcase
        return r;
    endfunction

    state_e     state;
    state_e     state_nxt;
    logic [1:0] lat_cnt;
    logic       req_fire;
    logic       legal;
    logic       capture;

    assign req_fire = req_valid && req_ready;
    assign legal    = call_op_e'(req_op) != OP_ILLEGAL;
    assign capture  = (state == ST_SETTLE) && (state_nxt == ST_RESP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            lat_cnt <= 2'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= (state_nxt != state) ? 2'd0 : lat_cnt + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:
                if (req_fire) state_nxt = legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE:
                if (lat_cnt == 2'(ISSUE_LAT - 1)) state_nxt = ST_SETTLE;
            ST_SETTLE:
                if (lat_cnt == 2'(SETTLE_LAT - 1)) state_nxt = ST_RESP;
            ST_RESP:
                if (rsp_ready) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
    end

    // tick_params_x is a one-shot: the target accumulates it every edge it is nonzero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_op                  <= 3'd0;
            rsp_data                <= 32'd0;
            rsp_err                 <= 1'b0;
            issued_count            <= '0;
            func_params_return_x    <= 32'd0;
            tock_params_no_return_x <= 32'd0;
            tock_params_return_x    <= 32'd0;
            tock_calls_funcs_x      <= 32'd0;
            tick_params_x           <= 32'd0;
        end else begin
            if (state == ST_ISSUE) tick_params_x <= 32'd0;
            if (req_fire) begin
                rsp_op <= req_op;
                if (legal) begin
                    issued_count <= issued_count + CNT_W'(1);
                    unique case (call_op_e'(req_op))
                        OP_FUNC_P:       func_params_return_x    <= req_arg;
                        OP_TOCK_P_NORET: tock_params_no_return_x <= req_arg;
                        OP_TOCK_P_RET:   tock_params_return_x    <= req_arg;
                        OP_TOCK_FUNCS:   tock_calls_funcs_x      <= req_arg;
                        OP_TICK_P:       tick_params_x           <= req_arg;
                        default:         ;
                    endcase
                end else begin
                    rsp_err  <= 1'b1;
                    rsp_data <= 32'd0;
                end
            end
            if (capture) begin
                rsp_data <= sel_result(call_op_e'(rsp_op),
                                       func_no_params_return_ret,
                                       func_params_return_ret,
                                       tock_no_params_return_ret,
                                       my_sig3,
                                       tock_params_return_ret,
                                       my_sig5,
                                       my_reg2);
                rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_module_call_dispatcher.sv
// Bench for module_call_dispatcher with a behavioural target model
// and a scoreboard of expected responses.
module tb_module_call_dispatcher;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_arg = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_op;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] issued_count;
    logic [31:0] func_params_return_x;
    logic [31:0] tock_params_no_return_x;
    logic [31:0] tock_params_return_x;
    logic [31:0] tock_calls_funcs_x;
    logic [31:0] tick_params_x;
    logic [31:0] func_no_params_return_ret;
    logic [31:0] func_params_return_ret;
    logic [31:0] tock_no_params_return_ret;
    logic [31:0] my_sig3;
    logic [31:0] tock_params_return_ret;
    logic [31:0] my_sig5;
    logic [31:0] my_reg2 = 32'd1000;

    always #5 clock = ~clock;

    // Target model: combinational returns plus a free-running accumulator
    assign func_no_params_return_ret = 32'd100;
    assign func_params_return_ret    = func_params_return_x + 32'd1;
    assign tock_no_params_return_ret = 32'd200;
    assign my_sig3                   = tock_params_no_return_x + 32'd12;
    assign tock_params_return_ret    = tock_params_return_x << 1;
    assign my_sig5                   = tock_calls_funcs_x + 32'd13;
    always @(posedge clock) my_reg2 <= my_reg2 + tick_params_x;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    module_call_dispatcher #(.CNT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_arg(req_arg),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_op(rsp_op),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .issued_count(issued_count),
        .func_params_return_x(func_params_return_x),
        .tock_params_no_return_x(tock_params_no_return_x),
        .tock_params_return_x(tock_params_return_x),
        .tock_calls_funcs_x(tock_calls_funcs_x),
        .tick_params_x(tick_params_x),
        .func_no_params_return_ret(func_no_params_return_ret),
        .func_params_return_ret(func_params_return_ret),
        .tock_no_params_return_ret(tock_no_params_return_ret),
        .my_sig3(my_sig3),
        .tock_params_return_ret(tock_params_return_ret),
        .my_sig5(my_sig5),
        .my_reg2(my_reg2)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] target_result(input logic [2:0] op,
                                                  input logic [31:0] arg);
        case (op)
            3'd0:    return 32'd100;
            3'd1:    return arg + 32'd1;
            3'd2:    return 32'd200;
            3'd3:    return arg + 32'd12;
            3'd4:    return arg << 1;
            3'd5:    return arg + 32'd13;
            3'd6:    return my_reg2 + arg;
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] arg);
        exp_t e;
        int   n;
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_arg   = arg;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) check_eq("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        e.op   = op;
        e.err  = (op == 3'd7);
        e.data = target_result(op, arg);
        e.lat  = e.err ? 1 : 3;
        e.acc  = cyc;
        if (!e.err) exp_cnt++;
        sb.push_back(e);
    endtask

    task automatic receive(input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            check_eq("rsp_valid_timeout", 32'd0, 32'd1);
            return;
        end
        check_eq("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        check_eq("rsp_op", 32'(rsp_op), 32'(e.op));
        check_eq("rsp_data", rsp_data, e.data);
        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
        if (hold > 0) begin
            req_valid = 1'b1;
            req_op    = 3'd1;
            req_arg   = 32'd77;
            for (int i = 0; i < hold; i++) begin
                @(posedge clock);
                #1;
                check_eq("hold_valid", 32'(rsp_valid), 32'd1);
                check_eq("hold_data", rsp_data, e.data);
                check_eq("hold_req_ready", 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            check_eq("hold_count", 32'(issued_count), 32'(exp_cnt));
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    logic [31:0] r_snap;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_count", 32'(issued_count), 32'd0);
        check_eq("rst_tick", tick_params_x, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        issue(3'd1, 32'd41);
        receive(0);
        check_eq("fp_x", func_params_return_x, 32'd41);
        check_eq("count1", 32'(issued_count), 32'(exp_cnt));

        issue(3'd6, 32'd5);
        check_eq("tick_on", tick_params_x, 32'd5);
        @(posedge clock);
        #1;
        check_eq("tick_off", tick_params_x, 32'd0);
        receive(0);

        issue(3'd7, 32'd123);
        receive(0);
        check_eq("count_illegal", 32'(issued_count), 32'(exp_cnt));

        issue(3'd5, 32'h7FFF_FFFF);
        receive(0);
        issue(3'd3, 32'hFFFF_FFF4);
        receive(0);
        issue(3'd0, 32'd9);
        receive(0);
        issue(3'd2, 32'd9);
        receive(0);

        issue(3'd4, 32'd7);
        receive(10);
        check_eq("tpr_x", tock_params_return_x, 32'd7);
        check_eq("fp_x_hold", func_params_return_x, 32'd41);

        issue(3'd6, 32'd9);
        check_eq("tick_pre_rst", tick_params_x, 32'd9);
        r_snap = my_reg2;
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        exp_cnt = 16'd0;
        check_eq("mid_rst_tick", tick_params_x, 32'd0);
        check_eq("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_count", 32'(issued_count), 32'd0);
        check_eq("mid_rst_fp_x", func_params_return_x, 32'd0);
        check_eq("mid_rst_tpr_x", tock_params_return_x, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check_eq("my_reg2_frozen", my_reg2, r_snap);
        @(negedge clock);
        reset = 1'b0;

        issue(3'd1, 32'hFFFF_FFFF);
        receive(0);
        check_eq("count_after_rst", 32'(issued_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
